// File: rtl/ncl_pkg.sv
// ncl_pkg: shared NCL state and dual-rail encoding definitions
package ncl_pkg;
    typedef enum logic {S_NULL, S_DATA} state_t;
    localparam logic [1:0] NULL_RAIL = 2'b00;
    localparam logic [1:0] DATA0     = 2'b01;
    localparam logic [1:0] DATA1     = 2'b10;
    localparam logic [1:0] ILLEGAL   = 2'b11;
    function automatic logic [1:0] rail(input logic v);
        return v ? DATA1 : DATA0;
    endfunction
endpackage

// File: rtl/ncl_flag_unit_if.sv
// ncl_flag_unit_if: dual-rail operand in, dual-rail flags and status out
interface ncl_flag_unit_if #(parameter int WIDTH = 8, parameter int CNT_W = 8);
    logic [WIDTH-1:0] in_t;
    logic [WIDTH-1:0] in_f;
    logic             ki;
    logic             ko;
    logic             zero_t;
    logic             zero_f;
    logic             neg_t;
    logic             neg_f;
    logic             par_t;
    logic             par_f;
    logic             err;
    logic [CNT_W-1:0] tok_cnt;
    modport master(output in_t, in_f, ki, input ko, zero_t, zero_f, neg_t, neg_f, par_t, par_f, err, tok_cnt);
    modport slave(input in_t, in_f, ki, output ko, zero_t, zero_f, neg_t, neg_f, par_t, par_f, err, tok_cnt);
endinterface

// File: rtl/ncl_completion.sv
// ncl_completion: dual-rail completion detection over a WIDTH-bit operand
module ncl_completion #(parameter int WIDTH = 8) (
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_f,
    output logic             all_data,
    output logic             all_null,
    output logic             illegal
);
    // an 11 bit fails the XOR test, so it never counts as DATA or NULL
    assign all_data = &(in_t ^ in_f);
    assign all_null = ~|(in_t | in_f);
    assign illegal  = |(in_t & in_f);
endmodule

// File: rtl/ncl_flag_unit.sv
// ncl_flag_unit: registered dual-rail zero/negative/parity flags under a four-phase handshake
module ncl_flag_unit
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    ncl_flag_unit_if.slave bus
);
    state_t           state_q, state_d;
    logic             all_data, all_null, illegal;
    logic             zero_q, neg_q, par_q, err_q;
    logic [CNT_W-1:0] tok_q;
    logic             accept;

    ncl_completion #(.WIDTH(WIDTH)) u_comp (
        .in_t    (bus.in_t),
        .in_f    (bus.in_f),
        .all_data(all_data),
        .all_null(all_null),
        .illegal (illegal)
    );

    assign accept = state_q == S_NULL && state_d == S_DATA;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_NULL;
        else     state_q <= state_d;
    end

    // next state: an illegal code freezes the handshake where it stands
    always_comb begin
        state_d = state_q;
        if (!illegal)
            state_d = state_q == S_NULL ? (all_data && bus.ki ? S_DATA : S_NULL)
                                        : (all_null && !bus.ki ? S_NULL : S_DATA);
    end

    // flag capture on accept, sticky error, wavefront counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            par_q  <= 1'b0;
            err_q  <= 1'b0;
            tok_q  <= '0;
        end else begin
            if (accept) begin
                zero_q <= &bus.in_f;
                neg_q  <= bus.in_t[WIDTH-1];
                par_q  <= ^bus.in_t;
                tok_q  <= tok_q + CNT_W'(1);
            end
            if (illegal) err_q <= 1'b1;
        end
    end

    // outputs decode from registered state only, so rails drop to NULL as soon as reset hits
    always_comb begin
        bus.ko                   = state_q == S_NULL;
        {bus.zero_t, bus.zero_f} = state_q == S_DATA ? rail(zero_q) : NULL_RAIL;
        {bus.neg_t, bus.neg_f}   = state_q == S_DATA ? rail(neg_q) : NULL_RAIL;
        {bus.par_t, bus.par_f}   = state_q == S_DATA ? rail(par_q) : NULL_RAIL;
        bus.err                  = err_q;
        bus.tok_cnt              = tok_q;
    end
endmodule

// File: tb/tb_ncl_flag_unit.sv
// tb_ncl_flag_unit: scoreboard bench for ncl_flag_unit
module tb_ncl_flag_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [9:0] sb[$];
    logic ms, mz, mn, mp, merr;
    logic [1:0] mcnt;

    always #5 clk = ~clk;

    ncl_flag_unit_if #(.WIDTH(8), .CNT_W(2)) bus ();
    ncl_flag_unit #(.WIDTH(8), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [9:0] obs();
        return {bus.ko, bus.zero_t, bus.zero_f, bus.neg_t, bus.neg_f, bus.par_t, bus.par_f, bus.err, bus.tok_cnt};
    endfunction

    function automatic logic [9:0] mvec();
        return {!ms, ms & mz, ms & !mz, ms & mn, ms & !mn, ms & mp, ms & !mp, merr, mcnt};
    endfunction

    task automatic model(input logic [7:0] t, input logic [7:0] f, input logic k);
        bit ill = 0, dat = 1, nul = 1;
        for (int i = 0; i < 8; i++) begin
            if (t[i] && f[i]) ill = 1;
            if (t[i] == f[i]) dat = 0;
            if (t[i] || f[i]) nul = 0;
        end
        if (ill) merr = 1;
        else if (!ms && dat && k) begin
            ms = 1;
            mz = t == 8'h00;
            mn = t[7];
            mp = ^t;
            mcnt = mcnt + 2'd1;
        end else if (ms && nul && !k) ms = 0;
    endtask

    task automatic step(input logic [7:0] t, input logic [7:0] f, input logic k, input string tag);
        @(negedge clk);
        rst = 1'b0;
        bus.in_t = t;
        bus.in_f = f;
        bus.ki = k;
        model(t, f, k);
        sb.push_back(mvec());
        @(posedge clk);
        #1;
        if (sb.size() == 0) check({tag, "_empty"}, 1, 0);
        else check(tag, obs(), sb.pop_front());
    endtask

    initial begin
        logic [7:0] op;
        bus.in_t = '0;
        bus.in_f = '0;
        bus.ki = 1'b0;
        ms = 0; mz = 0; mn = 0; mp = 0; merr = 0; mcnt = 0;
        #1;
        check("reset_state", obs(), 10'b1_000000_0_00);
        @(negedge clk);
        step(8'h00, 8'hFF, 1'b1, "zero_op");
        check("zero_t", bus.zero_t, 1);
        check("zero_neg_f", bus.neg_f, 1);
        check("zero_par_f", bus.par_f, 1);
        check("zero_ko", bus.ko, 0);
        check("zero_cnt", bus.tok_cnt, 1);
        step(8'h00, 8'h00, 1'b1, "null_wait_ki");
        check("null_wait_ko", bus.ko, 0);
        step(8'h00, 8'h00, 1'b0, "null1");
        step(8'h81, 8'h7E, 1'b1, "op81");
        check("op81_flags", {bus.zero_f, bus.neg_t, bus.par_f}, 3'b111);
        step(8'h80, 8'h70, 1'b0, "partial_null");
        check("partial_flags", {bus.zero_f, bus.neg_t, bus.par_f, bus.ko}, 4'b1110);
        step(8'h00, 8'h00, 1'b0, "full_null");
        check("full_null_ko", {bus.ko, bus.zero_t, bus.zero_f, bus.neg_t, bus.neg_f, bus.par_t, bus.par_f}, 7'b1000000);
        for (int i = 0; i < 5; i++) step(8'h01, 8'hFE, 1'b0, "stall");
        check("stall_ko", bus.ko, 1);
        step(8'h01, 8'hFE, 1'b1, "stall_release");
        check("release_par_t", bus.par_t, 1);
        check("release_cnt", bus.tok_cnt, 3);
        step(8'h00, 8'h00, 1'b0, "null2");
        step(8'h08, 8'hFF, 1'b1, "illegal");
        check("illegal_err", bus.err, 1);
        check("illegal_ko", bus.ko, 1);
        step(8'h00, 8'hFF, 1'b1, "illegal_cleared");
        check("cleared_err", bus.err, 1);
        check("cleared_zero_t", bus.zero_t, 1);
        check("wrap_cnt", bus.tok_cnt, 0);
        step(8'h00, 8'h00, 1'b0, "null3");
        for (int i = 0; i < 8; i++) begin
            op = 8'($urandom);
            step(op, ~op, 1'b1, "rand_data");
            if ($urandom_range(1) == 1) step(8'h00, 8'h00, 1'b1, "rand_hold");
            step(8'h00, 8'h00, 1'b0, "rand_null");
        end
        step(8'hC3, 8'h3C, 1'b1, "pre_reset");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_reset", obs(), 10'b1_000000_0_00);
        ms = 0; merr = 0; mcnt = 0;
        step(8'h81, 8'h7E, 1'b1, "post_reset_accept");
        check("post_reset_cnt", bus.tok_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
